// File: rtl/mac_dot_sequencer.sv
// -----------------------------------------------------------------------------
// mac_dot_sequencer
//
// Sequences one dot product  acc = e_in + sum(a_i * b_i)  (mod 2^16) through an
// external multiply-add PE. The block does not multiply. For each term it
// fetches an operand pair from the stream and issues a single a*b+c request to
// the PE. It then waits for the PE to signal completion and folds the result
// back into the accumulator. When all terms are done, the result is offered on
// the output handshake, reduced mod 2^LOGQ.
//
// Handshakes (valid/ready): a transfer happens on the rising edge where both
// valid and ready are high. The producer holds its data stable while valid is
// high and ready is low. Ready never depends combinationally on valid.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   start, len, e_in   job request (sampled only in IDLE)
//   s_valid/s_ready    operand stream handshake, payload s_a (8b), s_b (16b)
//   pe_en              one-cycle start pulse to the PE
//   pe_a/pe_b/pe_c     PE operands (multiplicand, multiplier, addend = acc)
//   pe_result/pe_done  PE sum and one-cycle completion pulse
//   out_valid/out_ready, out_data   result handshake
//   busy               high whenever the sequencer is not idle
//   dbg_state          current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module mac_dot_sequencer #(
  parameter int LEN_W = 11,
  parameter int LOGQ  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      e_in,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_a,
  input  logic [15:0]      s_b,
  output logic             pe_en,
  output logic [7:0]       pe_a,
  output logic [15:0]      pe_b,
  output logic [15:0]      pe_c,
  input  logic [15:0]      pe_result,
  input  logic             pe_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  // Low LOGQ bits set; the reduction is applied only at the output so the
  // accumulator always carries the full 16-bit PE result.
  localparam logic [15:0] OUT_MASK = 16'((32'h1 << LOGQ) - 32'h1);

  state_t           state;
  logic [15:0]      acc;
  logic [LEN_W-1:0] cnt;
  logic [7:0]       op_a;
  logic [15:0]      op_b;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= e_in;
            cnt   <= len;
            // An empty dot product is just the error term.
            state <= (len == '0) ? S_OUT : S_FETCH;
          end
        end

        S_FETCH: begin
          if (s_valid) begin
            op_a  <= s_a;
            op_b  <= s_b;
            state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          // The op registers and acc stay untouched until this point, so the
          // PE sees stable operands for its whole latency.
          if (pe_done) begin
            acc   <= pe_result;
            cnt   <= cnt - LEN_W'(1);
            state <= (cnt == LEN_W'(1)) ? S_OUT : S_FETCH;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Pure decodes of the state register: no input reaches these outputs
  // combinationally, and async reset clears them immediately.
  assign s_ready   = (state == S_FETCH);
  assign pe_en     = (state == S_ISSUE);
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  assign pe_a     = op_a;
  assign pe_b     = op_b;
  assign pe_c     = acc;
  assign out_data = acc & OUT_MASK;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
module tb_mac_dot_sequencer;

  // ---------------- clock / reset / stimulus signals ----------------
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [10:0] len = '0;
  logic [15:0] e_in = '0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_a = '0;
  logic [15:0] s_b = '0;
  logic        out_ready = 1'b0;
  logic        inj_done = 1'b0;

  logic        s_ready, pe_en, out_valid, busy, pe_done;
  logic [7:0]  pe_a;
  logic [15:0] pe_b, pe_c, pe_result, out_data;
  logic [2:0]  dbg_state;

  // Outputs of the LOGQ=8 and LOGQ=15 instances (only out_data is checked).
  logic        s_ready8, pe_en8, out_valid8, busy8;
  logic [7:0]  pe_a8;
  logic [15:0] pe_b8, pe_c8, out_data8;
  logic [2:0]  dbg_state8;
  logic        s_ready15, pe_en15, out_valid15, busy15;
  logic [7:0]  pe_a15;
  logic [15:0] pe_b15, pe_c15, out_data15;
  logic [2:0]  dbg_state15;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mac_dot_sequencer #(.LEN_W(11), .LOGQ(16)) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .e_in(e_in),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .pe_en(pe_en), .pe_a(pe_a), .pe_b(pe_b), .pe_c(pe_c),
    .pe_result(pe_result), .pe_done(pe_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  mac_dot_sequencer #(.LEN_W(11), .LOGQ(8)) u_dut8 (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .e_in(e_in),
    .s_valid(s_valid), .s_ready(s_ready8), .s_a(s_a), .s_b(s_b),
    .pe_en(pe_en8), .pe_a(pe_a8), .pe_b(pe_b8), .pe_c(pe_c8),
    .pe_result(pe_result), .pe_done(pe_done),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
    .busy(busy8), .dbg_state(dbg_state8)
  );

  mac_dot_sequencer #(.LEN_W(11), .LOGQ(15)) u_dut15 (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .e_in(e_in),
    .s_valid(s_valid), .s_ready(s_ready15), .s_a(s_a), .s_b(s_b),
    .pe_en(pe_en15), .pe_a(pe_a15), .pe_b(pe_b15), .pe_c(pe_c15),
    .pe_result(pe_result), .pe_done(pe_done),
    .out_valid(out_valid15), .out_ready(out_ready), .out_data(out_data15),
    .busy(busy15), .dbg_state(dbg_state15)
  );

  // ---------------- two-cycle PE model ----------------
  logic        pe_r1 = 1'b0;
  logic        pe_done_q = 1'b0;
  logic [15:0] pe_res_q = '0;

  always @(posedge clk) begin
    pe_r1     <= pe_en;
    pe_done_q <= pe_r1;
    if (pe_en) pe_res_q <= 16'(pe_a * pe_b + pe_c);
  end
  assign pe_done   = pe_done_q | inj_done;
  assign pe_result = pe_res_q;

  // ---------------- monitor ----------------
  int          en_cnt = 0;
  int          sr_cnt = 0;
  int          stab_viol = 0;
  bit          pend = 1'b0;
  logic [39:0] cap = '0;
  logic [15:0] pec_q[$];

  always @(posedge clk) begin
    if (!rstn) begin
      pend = 1'b0;
    end else begin
      if (pend && ({pe_a, pe_b, pe_c} !== cap)) stab_viol++;
      if (pend && pe_done) pend = 1'b0;
      if (pe_en) begin
        pend = 1'b1;
        cap  = {pe_a, pe_b, pe_c};
        en_cnt++;
        pec_q.push_back(pe_c);
      end
      if (s_ready) sr_cnt++;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  job_a[64];
  logic [15:0] job_b[64];
  logic [15:0] exp_q[$];

  function automatic logic [15:0] model_dot(input logic [15:0] e, input int n, input int logq);
    longint s;
    s = longint'(e);
    for (int i = 0; i < n; i++) s += longint'(job_a[i]) * longint'(job_b[i]);
    s = s % 65536;
    return 16'(s % (longint'(1) << logq));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_pairs(input int first, input int n, input int max_gap, output bit to);
    int b;
    to = 1'b0;
    for (int i = first; i < first + n; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      s_valid = 1'b0;
      repeat (g) tick();
      s_valid = 1'b1;
      s_a = job_a[i];
      s_b = job_b[i];
      b = 0;
      while (!s_ready && b < 200) begin tick(); b++; end
      if (b >= 200) to = 1'b1;
      tick();
      s_valid = 1'b0;
      s_a = 8'($urandom);
      s_b = 16'($urandom);
    end
  endtask

  task automatic run_job(input int n, input logic [15:0] e, input int max_gap, input int max_rdy,
                         output logic [15:0] o16, output logic [15:0] o8, output logic [15:0] o15,
                         output int lat, output bit to);
    int t0, b;
    bit fto;
    start = 1'b1;
    len = 11'(n);
    e_in = e;
    t0 = cyc;
    tick();
    start = 1'b0;
    len = 11'($urandom);
    e_in = 16'($urandom);
    feed_pairs(0, n, max_gap, fto);
    to = fto;
    b = 0;
    while (!out_valid && b < 200) begin tick(); b++; end
    if (b >= 200) to = 1'b1;
    lat = cyc - t0;
    o16 = out_data;
    o8 = out_data8;
    o15 = out_data15;
    repeat ((max_rdy > 0) ? int'($urandom_range(0, max_rdy)) : 0) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({pe_en, s_ready, out_valid, busy} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected 0000", {pe_en, s_ready, out_valid, busy});
    end
    n_checks++;
    if ({out_data, pe_a, pe_b, pe_c} !== 56'd0) begin
      n_errors++;
      $display("FAIL reset_data: got %h expected 0", {out_data, pe_a, pe_b, pe_c});
    end
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    n_checks++;
    if ({busy, out_valid} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_release_idle: got %b expected 00", {busy, out_valid});
    end
  endtask

  task automatic test_single();
    logic [15:0] o16, o8, o15;
    int lat, en0;
    bit to;
    en0 = en_cnt;
    job_a[0] = 8'd3;
    job_b[0] = 16'd7;
    run_job(1, 16'd5, 0, 0, o16, o8, o15, lat, to);
    n_checks++;
    if (to !== 1'b0) begin n_errors++; $display("FAIL single_timeout: got %b expected 0", to); end
    n_checks++;
    if (o16 !== 16'd26 || o16 !== model_dot(16'd5, 1, 16)) begin
      n_errors++; $display("FAIL single_data: got %0d expected 26", o16);
    end
    n_checks++;
    if (lat !== 5) begin n_errors++; $display("FAIL single_latency: got %0d expected 5", lat); end
    n_checks++;
    if (en_cnt - en0 !== 1) begin n_errors++; $display("FAIL single_pe_en: got %0d expected 1", en_cnt - en0); end
  endtask

  task automatic test_three();
    logic [15:0] o16, o8, o15, c;
    int lat, en0;
    bit to;
    en0 = en_cnt;
    pec_q.delete();
    job_a[0] = 8'd1; job_b[0] = 16'd2;
    job_a[1] = 8'd2; job_b[1] = 16'd3;
    job_a[2] = 8'd4; job_b[2] = 16'd5;
    run_job(3, 16'd0, 0, 0, o16, o8, o15, lat, to);
    n_checks++;
    if (to !== 1'b0 || o16 !== 16'd28) begin
      n_errors++; $display("FAIL three_data: got %0d (timeout %b) expected 28", o16, to);
    end
    n_checks++;
    if (en_cnt - en0 !== 3) begin n_errors++; $display("FAIL three_pe_en: got %0d expected 3", en_cnt - en0); end
    c = 16'd0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (pec_q.size() == 0) begin
        n_errors++; $display("FAIL three_pe_c[%0d]: got none expected %0d", i, c);
      end else begin
        logic [15:0] got;
        got = pec_q.pop_front();
        if (got !== c) begin n_errors++; $display("FAIL three_pe_c[%0d]: got %0d expected %0d", i, got, c); end
      end
      c = 16'(c + job_a[i] * job_b[i]);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] o16, o8, o15;
    int lat;
    bit to;
    job_a[0] = 8'd255;
    job_b[0] = 16'hFFFF;
    run_job(1, 16'h0100, 0, 0, o16, o8, o15, lat, to);
    n_checks++;
    if (o16 !== 16'h0001) begin n_errors++; $display("FAIL wrap_q16: got %h expected 0001", o16); end
    n_checks++;
    if (o8 !== 16'h0001) begin n_errors++; $display("FAIL wrap_q8: got %h expected 0001", o8); end
    job_a[0] = 8'd1;
    job_b[0] = 16'h8000;
    run_job(1, 16'h0000, 0, 0, o16, o8, o15, lat, to);
    n_checks++;
    if (o15 !== 16'h0000) begin n_errors++; $display("FAIL wrap_q15: got %h expected 0000", o15); end
    n_checks++;
    if (o16 !== 16'h8000 || to !== 1'b0) begin
      n_errors++; $display("FAIL wrap_q16_b: got %h (timeout %b) expected 8000", o16, to);
    end
  endtask

  task automatic test_len0();
    logic [15:0] o16, o8, o15;
    int lat, en0, sr0;
    bit to;
    en0 = en_cnt;
    sr0 = sr_cnt;
    run_job(0, 16'h1234, 0, 0, o16, o8, o15, lat, to);
    n_checks++;
    if (o16 !== 16'h1234) begin n_errors++; $display("FAIL len0_data: got %h expected 1234", o16); end
    n_checks++;
    if (lat !== 1) begin n_errors++; $display("FAIL len0_latency: got %0d expected 1", lat); end
    n_checks++;
    if (en_cnt !== en0 || sr_cnt !== sr0) begin
      n_errors++; $display("FAIL len0_no_stream: got pe_en %0d s_ready %0d expected 0 0", en_cnt - en0, sr_cnt - sr0);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] e, d, expd;
    int en0, b;
    bit to, held, stable;
    e = 16'($urandom);
    for (int i = 0; i < 2; i++) begin job_a[i] = 8'($urandom); job_b[i] = 16'($urandom); end
    expd = model_dot(e, 2, 16);
    en0 = en_cnt;
    start = 1'b1; len = 11'd2; e_in = e;
    tick();
    held = 1'b1;
    repeat (10) begin
      start = 1'b1; len = 11'd1; e_in = 16'hDEAD;
      tick();
      if (s_ready !== 1'b1 || busy !== 1'b1 || en_cnt !== en0) held = 1'b0;
    end
    start = 1'b0;
    n_checks++;
    if (held !== 1'b1) begin n_errors++; $display("FAIL bp_fetch_hold: got %b expected 1", held); end
    feed_pairs(0, 2, 0, to);
    b = 0;
    while (!out_valid && b < 200) begin tick(); b++; end
    d = out_data;
    stable = 1'b1;
    repeat (7) begin
      start = 1'b1;
      tick();
      if (out_valid !== 1'b1 || out_data !== d) stable = 1'b0;
    end
    start = 1'b0;
    n_checks++;
    if (stable !== 1'b1) begin n_errors++; $display("FAIL bp_out_hold: got %b expected 1", stable); end
    n_checks++;
    if (d !== expd || to !== 1'b0 || b >= 200) begin
      n_errors++; $display("FAIL bp_data: got %h expected %h", d, expd);
    end
    n_checks++;
    if (en_cnt - en0 !== 2) begin n_errors++; $display("FAIL bp_pe_en: got %0d expected 2", en_cnt - en0); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if ({busy, out_valid} !== 2'b00) begin n_errors++; $display("FAIL bp_idle: got %b expected 00", {busy, out_valid}); end
    n_checks++;
    if (stab_viol !== 0) begin n_errors++; $display("FAIL bp_pe_stable: got %0d expected 0", stab_viol); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] o16, o8, o15;
    int lat;
    bit to, quiet;
    for (int i = 0; i < 3; i++) begin job_a[i] = 8'($urandom_range(1, 255)); job_b[i] = 16'($urandom_range(1, 65535)); end
    start = 1'b1; len = 11'd3; e_in = 16'($urandom);
    tick();
    start = 1'b0;
    feed_pairs(0, 2, 0, to);
    tick();
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({pe_en, s_ready, out_valid, busy} !== 4'b0000 || {out_data, pe_a, pe_b, pe_c} !== 56'd0) begin
      n_errors++;
      $display("FAIL midreset_outputs: got %b %h expected 0", {pe_en, s_ready, out_valid, busy},
               {out_data, pe_a, pe_b, pe_c});
    end
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0 || pe_c !== 16'd0) quiet = 1'b0;
    end
    n_checks++;
    if (quiet !== 1'b1) begin n_errors++; $display("FAIL midreset_quiet: got %b expected 1", quiet); end
    job_a[0] = 8'($urandom);
    job_b[0] = 16'($urandom);
    run_job(1, 16'h00AA, 0, 0, o16, o8, o15, lat, to);
    n_checks++;
    if (o16 !== model_dot(16'h00AA, 1, 16) || to !== 1'b0) begin
      n_errors++; $display("FAIL midreset_newjob: got %h expected %h", o16, model_dot(16'h00AA, 1, 16));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] o16, o8, o15, e2;
    int lat;
    bit to;
    job_a[0] = 8'd9; job_b[0] = 16'd11;
    run_job(1, 16'd1, 0, 0, o16, o8, o15, lat, to);
    n_checks++;
    if (o16 !== model_dot(16'd1, 1, 16) || busy !== 1'b0) begin
      n_errors++; $display("FAIL b2b_first: got %0d busy %b expected %0d busy 0", o16, busy, model_dot(16'd1, 1, 16));
    end
    job_a[0] = 8'($urandom); job_b[0] = 16'($urandom);
    e2 = 16'($urandom);
    run_job(1, e2, 0, 0, o16, o8, o15, lat, to);
    n_checks++;
    if (o16 !== model_dot(e2, 1, 16) || lat !== 5 || to !== 1'b0) begin
      n_errors++; $display("FAIL b2b_second: got %h lat %0d expected %h lat 5", o16, lat, model_dot(e2, 1, 16));
    end
  endtask

  task automatic test_random();
    logic [15:0] o16, o8, o15, e, exp16, exp8, exp15;
    int n, lat, en0, tot;
    bit to;
    en0 = en_cnt;
    tot = 0;
    for (int j = 0; j < 25; j++) begin
      n = $urandom_range(0, 6);
      e = 16'($urandom);
      for (int i = 0; i < n; i++) begin job_a[i] = 8'($urandom); job_b[i] = 16'($urandom); end
      exp_q.push_back(model_dot(e, n, 16));
      exp_q.push_back(model_dot(e, n, 8));
      exp_q.push_back(model_dot(e, n, 15));
      tot += n;
      run_job(n, e, 3, 3, o16, o8, o15, lat, to);
      exp16 = exp_q.pop_front();
      exp8 = exp_q.pop_front();
      exp15 = exp_q.pop_front();
      n_checks++;
      if (o16 !== exp16 || o8 !== exp8 || o15 !== exp15 || to !== 1'b0) begin
        n_errors++;
        $display("FAIL random_job%0d: got %h/%h/%h expected %h/%h/%h", j, o16, o8, o15, exp16, exp8, exp15);
      end
    end
    n_checks++;
    if (en_cnt - en0 !== tot) begin n_errors++; $display("FAIL random_pe_en: got %0d expected %0d", en_cnt - en0, tot); end
    n_checks++;
    if (stab_viol !== 0) begin n_errors++; $display("FAIL random_pe_stable: got %0d expected 0", stab_viol); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_three();
    test_wrap();
    test_len0();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
